// File: rtl/rr_arbiter_8x3.sv
// Round-robin arbiter for 8 requesters. The grant goes out as a binary index
// with a valid flag, and is held until done, a request drop, or a timeout.
module rr_arbiter_8x3 #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    state_t           state_nx;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       winner;
    logic             grant_now;
    logic             release_now;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_tmo;

    // Scan from ptr+8 down to ptr+1 so the nearest request after ptr wins last;
    // ptr itself (offset 8) has the lowest priority.
    always_comb begin
        winner = ptr;
        for (int i = 8; i >= 1; i--) begin
            if (req[ptr + 3'(i)]) winner = ptr + 3'(i);
        end
    end

    always_comb begin
        state_nx    = state;
        rel_done    = done;
        rel_drop    = !req[gnt_idx];
        rel_tmo     = TMO_EN && (cnt == TMO_LAST);
        grant_now   = (state == IDLE) && en && (req != 8'h00);
        release_now = (state == GRANT) && (rel_done || rel_drop || rel_tmo);
        case (state)
            IDLE:    if (grant_now)   state_nx = GRANT;
            GRANT:   if (release_now) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 3'd7;
            cnt     <= '0;
            gnt_idx <= 3'd0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            // Pulse only when the timeout alone ended the grant.
            timeout <= release_now && !rel_done && !rel_drop;
            if (grant_now) begin
                gnt_idx <= winner;
                ptr     <= winner;
                cnt     <= '0;
            end else if (state == GRANT && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign gnt_valid = (state == GRANT);
    assign busy      = (state == GRANT);

endmodule
